arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Upstream front end of priority_arbiter.
- Holds one small command FIFO per requester and drives the arbiter's req vector from the FIFO non-empty flags.
- Consumes the arbiter's one-hot grant to pop the granted head entry.
- Presents the popped entry, tagged with its requester ID, on a registered output strobe to the shared resource.

Parameters:
- NUM_REQ, 4, number of requesters; must match arbiter req/grant width.
- DEPTH, 4, entries per requester FIFO; power of two, at least 2.
- DATA_W, 8, command payload width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- push  input  NUM_REQ  per-requester write strobe.
- push_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
- req  output  NUM_REQ  to arbiter; req[i] = FIFO i non-empty (combinational from count).
- grant  input  NUM_REQ  from arbiter; one-hot or zero.
- full  output  NUM_REQ  FIFO i holds DEPTH entries.
- out_valid  output  1  one-cycle strobe; popped entry valid.
- out_data  output  DATA_W  popped payload.
- out_id  output  log2(NUM_REQ)  index of requester that was popped.
- err_push_full  output  1  sticky; push seen while full.
- err_grant  output  1  sticky; grant multi-hot, or grant to an empty FIFO.

Behaviour:
- Reset (rst=1 at posedge): all FIFO counts and pointers are 0.
  - req=0, full=0, out_valid=0, out_data=0, out_id=0, err_push_full=0, err_grant=0.
  - Reset mid-operation discards all queued entries; no out_valid is produced in the reset cycle.
- FIFO i write: on posedge with push[i]=1 and count_i<DEPTH:
  - write push_data slice at wr_ptr_i;
  - wr_ptr_i increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Push while full and not popping in the same cycle: data dropped, count unchanged, err_push_full set.
- Pop: on posedge with grant[i]=1, grant one-hot, and count_i>0:
  - read entry at rd_ptr_i; rd_ptr_i increments modulo DEPTH;
  - next cycle out_valid=1, out_data=entry, out_id=i. Latency is grant-to-output, 1 cycle.
- No valid pop in a cycle: out_valid=0; out_data and out_id hold their last values.
- Simultaneous push and pop on the same FIFO: both occur and count is unchanged.
  - This includes the full case: a pop frees a slot, so the push is accepted and err_push_full is not set.
  - Empty FIFO with push and grant: no pop; push accepted; err_grant set.
- Count width is log2(DEPTH)+1; it never exceeds DEPTH and never underflows.
- Grant to an empty FIFO is a no-op for the pop and sets err_grant.
  - This case is normal when the registered arbiter re-grants a FIFO just drained to 0, so benches must not treat it as fatal.
- Multi-hot grant: no pop on any FIFO; err_grant set.
- Zero grant: no pop, no error.
- Sticky errors clear only on rst.
- req[i] drops in the same cycle count_i reaches 0.
- There is no back-pressure on out_valid; the consumer must accept every strobe.

Test Plan:
- Reset check: hold rst 2 cycles with push=4'b1111 -> req=0, full=0, out_valid=0, both error flags 0; no entry is queued after release.
- Single requester order: push 0x11, 0x22, 0x33 into FIFO 2 over 3 cycles, then grant=4'b0100 for 3 cycles -> out_valid on the 3 following cycles with out_data 0x11, 0x22, 0x33 and out_id=2; req[2] falls after the third pop.
- Full and wrap: push 5 entries into FIFO 0 (DEPTH=4) -> full[0]=1 after the 4th; the 5th is dropped and err_push_full=1.
  - Then alternate a pop and a push 6 times -> FIFO order is preserved across pointer wrap.
- Simultaneous push+pop at full: FIFO 1 full, push 0xAA with grant=4'b0010 -> head popped, 0xAA accepted, count stays 4, err_push_full stays 0.
- Grant errors: grant=4'b0011 with FIFOs 0 and 1 non-empty -> no out_valid, counts unchanged, err_grant=1. After reset, grant=4'b1000 with FIFO 3 empty -> no out_valid, err_grant=1.
- Closed loop with priority_arbiter: random pushes for 200 cycles -> every pushed payload emerges exactly once with the correct out_id, per-requester order is preserved, and err_push_full stays 0 when pushes respect full.

Source files
------------

// File: rtl/arb_req_queue.sv
// Per-requester command FIFOs feeding priority_arbiter: req from non-empty flags,
// one-hot grant pops the head onto a registered, ID-tagged output strobe.
module arb_req_queue #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         push,
  input  logic [NUM_REQ*DATA_W-1:0]  push_data,
  output logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         full,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       err_push_full,
  output logic                       err_grant
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem    [NUM_REQ][DEPTH];
  logic [PW-1:0]     wr_ptr [NUM_REQ];
  logic [PW-1:0]     rd_ptr [NUM_REQ];
  logic [CW-1:0]     cnt    [NUM_REQ];

  logic               onehot;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] push_ok;
  logic [ID_W-1:0]    sel;
  logic               grant_bad;
  logic               push_drop;

  always_comb begin
    onehot = (grant != '0) && ((grant & (grant - NUM_REQ'(1))) == '0);
    sel    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req[i]     = (cnt[i] != '0);
      full[i]    = (cnt[i] == FULL_CNT);
      pop[i]     = grant[i] && onehot && req[i];
      // a pop in the same cycle frees a slot, so a push at full is still accepted
      push_ok[i] = push[i] && (!full[i] || pop[i]);
      if (grant[i]) sel = ID_W'(i);
    end
    // pop is non-zero exactly when the grant is one-hot onto a non-empty FIFO
    grant_bad = (grant != '0) && (pop == '0);
    push_drop = |(push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= push_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push_ok[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_id        <= '0;
      err_push_full <= 1'b0;
      err_grant     <= 1'b0;
    end else begin
      out_valid <= (pop != '0);
      if (pop != '0) begin
        out_data <= mem[sel][rd_ptr[sel]];
        out_id   <= sel;
      end
      if (push_drop) err_push_full <= 1'b1;
      if (grant_bad) err_grant     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: FIFO order, full/wrap, push+pop at full,
// grant errors and a closed loop against a lowest-index-first grant model.
module tb_arb_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  push;
  logic [31:0] push_data;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [3:0]  full;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        err_push_full;
  logic        err_grant;

  int total = 0;
  int bad   = 0;

  arb_req_queue #(.NUM_REQ(4), .DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .req(req),
    .grant(grant), .full(full), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .err_push_full(err_push_full), .err_grant(err_grant)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = '0; grant = '0; push_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_one(input int i, input logic [7:0] d);
    push = '0; push[i] = 1'b1;
    push_data = '0; push_data[i*8 +: 8] = d;
    step();
    push = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 4'b1111; push_data = 32'hDEADBEEF; grant = '0;
    step(); step();
    total++; if (req !== 4'b0000) begin bad++; $display("FAIL reset_req got %b exp 0000", req); end
    total++; if (full !== 4'b0000) begin bad++; $display("FAIL reset_full got %b exp 0000", full); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    total++; if ({err_push_full, err_grant} !== 2'b00) begin bad++; $display("FAIL reset_err got %b exp 00", {err_push_full, err_grant}); end
    total++; if ({out_data, out_id} !== 10'd0) begin bad++; $display("FAIL reset_out got %h/%0d exp 00/0", out_data, out_id); end
    rst = 1'b0; push = '0;
    step();
    total++; if (req !== 4'b0000) begin bad++; $display("FAIL reset_no_entry got %b exp 0000", req); end
  endtask

  task automatic test_order();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_reset();
    for (int k = 0; k < 3; k++) push_one(2, exp_d[k]);
    total++; if (req !== 4'b0100) begin bad++; $display("FAIL order_req got %b exp 0100", req); end
    grant = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_id !== 2'd2) begin
        bad++; $display("FAIL order_pop%0d got v=%b d=%h id=%0d exp v=1 d=%h id=2", k, out_valid, out_data, out_id, exp_d[k]);
      end
    end
    total++; if (req !== 4'b0000) begin bad++; $display("FAIL order_req_drop got %b exp 0000", req); end
    grant = '0;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h33 || out_id !== 2'd2) begin
      bad++; $display("FAIL order_hold got v=%b d=%h id=%0d exp v=0 d=33 id=2", out_valid, out_data, out_id);
    end
    total++; if (err_grant !== 1'b0) begin bad++; $display("FAIL order_err got %b exp 0", err_grant); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) push_one(0, 8'hA0 + 8'(k));
    total++; if (full !== 4'b0001 || err_push_full !== 1'b0) begin
      bad++; $display("FAIL wrap_full got full=%b err=%b exp full=0001 err=0", full, err_push_full);
    end
    push_one(0, 8'hA4);
    total++; if (full !== 4'b0001 || err_push_full !== 1'b1) begin
      bad++; $display("FAIL wrap_drop got full=%b err=%b exp full=0001 err=1", full, err_push_full);
    end
    for (int k = 0; k < 6; k++) begin
      e = (k < 4) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k - 4);
      grant = 4'b0001; step(); grant = '0;
      total++; if (out_valid !== 1'b1 || out_data !== e || out_id !== 2'd0) begin
        bad++; $display("FAIL wrap_pop%0d got v=%b d=%h id=%0d exp v=1 d=%h id=0", k, out_valid, out_data, out_id, e);
      end
      push_one(0, 8'hB0 + 8'(k));
    end
    grant = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      e = 8'hB2 + 8'(k);
      total++; if (out_valid !== 1'b1 || out_data !== e) begin
        bad++; $display("FAIL wrap_drain%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, e);
      end
    end
    grant = '0;
    total++; if (req !== 4'b0000) begin bad++; $display("FAIL wrap_empty got %b exp 0000", req); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) push_one(1, 8'hC0 + 8'(k));
    push = 4'b0010; push_data = '0; push_data[15:8] = 8'hAA; grant = 4'b0010;
    step();
    push = '0; grant = '0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'hC0 || out_id !== 2'd1) begin
      bad++; $display("FAIL ppfull_pop got v=%b d=%h id=%0d exp v=1 d=c0 id=1", out_valid, out_data, out_id);
    end
    total++; if (full !== 4'b0010 || err_push_full !== 1'b0) begin
      bad++; $display("FAIL ppfull_state got full=%b err=%b exp full=0010 err=0", full, err_push_full);
    end
    grant = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step();
      e = (k < 3) ? 8'hC1 + 8'(k) : 8'hAA;
      total++; if (out_data !== e || out_valid !== 1'b1) begin
        bad++; $display("FAIL ppfull_drain%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, e);
      end
    end
    grant = '0;
  endtask

  task automatic test_grant_err();
    do_reset();
    push = 4'b0011; push_data = 32'h0000_5150;
    step();
    push = '0; grant = 4'b0011;
    step();
    grant = '0;
    total++; if (out_valid !== 1'b0 || req !== 4'b0011 || err_grant !== 1'b1) begin
      bad++; $display("FAIL gerr_multi got v=%b req=%b err=%b exp v=0 req=0011 err=1", out_valid, req, err_grant);
    end
    grant = 4'b0001;
    step();
    total++; if (out_data !== 8'h50 || req !== 4'b0010) begin
      bad++; $display("FAIL gerr_kept got d=%h req=%b exp d=50 req=0010", out_data, req);
    end
    step();
    total++; if (err_grant !== 1'b1) begin bad++; $display("FAIL gerr_sticky got %b exp 1", err_grant); end
    grant = 4'b0010; rst = 1'b1;
    step();
    rst = 1'b0; grant = '0;
    total++; if (out_valid !== 1'b0 || req !== 4'b0000 || err_grant !== 1'b0) begin
      bad++; $display("FAIL gerr_midreset got v=%b req=%b err=%b exp v=0 req=0000 err=0", out_valid, req, err_grant);
    end
    grant = 4'b1000;
    step();
    total++; if (out_valid !== 1'b0 || err_grant !== 1'b1) begin
      bad++; $display("FAIL gerr_empty got v=%b err=%b exp v=0 err=1", out_valid, err_grant);
    end
    do_reset();
    push = 4'b1000; push_data = 32'h7700_0000; grant = 4'b1000;
    step();
    push = '0; grant = '0;
    total++; if (out_valid !== 1'b0 || req !== 4'b1000 || err_grant !== 1'b1) begin
      bad++; $display("FAIL gerr_push_empty got v=%b req=%b err=%b exp v=0 req=1000 err=1", out_valid, req, err_grant);
    end
  endtask

  task automatic test_closed_loop();
    logic [7:0] q [4][$];
    logic [7:0] exp_d;
    logic [7:0] d;
    logic [3:0] nonempty;
    int         gi;
    int         cyc;
    do_reset();
    cyc = 0;
    while (cyc < 260) begin
      nonempty = '0;
      for (int i = 0; i < 4; i++) nonempty[i] = (q[i].size() != 0);
      gi = -1;
      for (int i = 3; i >= 0; i--) if (nonempty[i]) gi = i;
      grant = '0; push = '0; push_data = '0;
      if (gi >= 0) grant[gi] = 1'b1;
      if (cyc < 200) begin
        for (int i = 0; i < 4; i++) begin
          if (q[i].size() < 4 && $urandom_range(0, 2) != 0) begin
            d = 8'($urandom);
            push[i] = 1'b1; push_data[i*8 +: 8] = d;
          end
        end
      end
      #1;
      if (req !== nonempty) begin
        total++; bad++; $display("FAIL loop_req cyc=%0d got %b exp %b", cyc, req, nonempty);
      end
      exp_d = '0;
      if (gi >= 0) exp_d = q[gi].pop_front();
      for (int i = 0; i < 4; i++) if (push[i]) q[i].push_back(push_data[i*8 +: 8]);
      step();
      total++;
      if (out_valid !== (gi >= 0)) begin
        bad++; $display("FAIL loop_valid cyc=%0d got %b exp %b", cyc, out_valid, gi >= 0);
      end else if (gi >= 0 && (out_data !== exp_d || out_id !== 2'(gi))) begin
        bad++; $display("FAIL loop_data cyc=%0d got d=%h id=%0d exp d=%h id=%0d", cyc, out_data, out_id, exp_d, gi);
      end
      cyc++;
      if (cyc >= 200 && nonempty == '0 && push == '0) break;
    end
    grant = '0; push = '0;
    total++; if (cyc >= 260) begin bad++; $display("FAIL loop_drain_timeout got cyc=%0d exp <260", cyc); end
    total++; if (req !== 4'b0000 || err_push_full !== 1'b0 || err_grant !== 1'b0) begin
      bad++; $display("FAIL loop_end got req=%b epf=%b eg=%b exp 0000/0/0", req, err_push_full, err_grant);
    end
  endtask

  initial begin
    rst = 1'b1; push = '0; push_data = '0; grant = '0;
    #2;
    test_reset();
    test_order();
    test_full_wrap();
    test_push_pop_full();
    test_grant_err();
    test_closed_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
